// File: rtl/ghash_sequencer.sv
// ghash_sequencer: drives a multi-block GHASH computation over an external
// ghash core. Accepts a subkey H, then a stream of 128-bit blocks. Each block
// is handed to the core together with the running partial hash. After the
// block flagged last, the final hash is offered on a valid/ready output.
//
// Optional feature macro: GHASH_SEQ_WDOG_EN
//   defined   -> a watchdog bounds each core wait to WDOG_CYCLES cycles. On
//                expiry it raises err and returns the FSM to IDLE.
//   undefined -> no watchdog; err is constant 0 and WAIT lasts until done.
module ghash_sequencer #(
   parameter int GHASH_BITS  = 128,
   parameter int SUBKEY_BITS = 128,
   parameter int WDOG_CYCLES = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [SUBKEY_BITS-1:0] cfg_subkey,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [GHASH_BITS-1:0]  s_data,
   input  logic                   s_last,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [GHASH_BITS-1:0]  m_ghash,
   output logic                   core_en,
   output logic [GHASH_BITS-1:0]  core_g_prev,
   output logic [GHASH_BITS-1:0]  core_data,
   output logic [SUBKEY_BITS-1:0] core_subkey,
   input  logic [GHASH_BITS-1:0]  core_ghash,
   input  logic                   core_done,
   output logic                   busy,
   output logic                   err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_OUT   = 3'd4
   } state_t;

   state_t                 r_state;
   logic [GHASH_BITS-1:0]  r_acc;
   logic [GHASH_BITS-1:0]  r_data;
   logic [SUBKEY_BITS-1:0] r_subkey;
   logic                   r_last_q;
   logic                   r_core_en;

`ifdef GHASH_SEQ_WDOG_EN
   // Counter wide enough to hold WDOG_CYCLES-1 for any positive limit.
   localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES + 1) : 1;
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

   logic [WDOG_W-1:0] r_wdog;
   logic              r_err;

   // Main sequencer FSM with watchdog on the core wait.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_acc     <= '0;
         r_data    <= '0;
         r_subkey  <= '0;
         r_last_q  <= 1'b0;
         r_core_en <= 1'b0;
         r_wdog    <= '0;
         r_err     <= 1'b0;
      end else begin
         r_core_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cfg_valid) begin
                  r_subkey <= cfg_subkey;
                  r_acc    <= '0;
                  r_err    <= 1'b0;
                  r_state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (s_valid) begin
                  r_data    <= s_data;
                  r_last_q  <= s_last;
                  r_core_en <= 1'b1;
                  r_state   <= S_START;
               end
            end
            S_START: begin
               r_wdog  <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (core_done) begin
                  r_acc   <= core_ghash;
                  r_state <= r_last_q ? S_OUT : S_LOAD;
               end else if (r_wdog == WDOG_LAST) begin
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_wdog <= r_wdog + WDOG_W'(1);
               end
            end
            S_OUT: begin
               if (m_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign err = r_err;
`else
   // Main sequencer FSM; the core wait is unbounded in this build.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_acc     <= '0;
         r_data    <= '0;
         r_subkey  <= '0;
         r_last_q  <= 1'b0;
         r_core_en <= 1'b0;
      end else begin
         r_core_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cfg_valid) begin
                  r_subkey <= cfg_subkey;
                  r_acc    <= '0;
                  r_state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (s_valid) begin
                  r_data    <= s_data;
                  r_last_q  <= s_last;
                  r_core_en <= 1'b1;
                  r_state   <= S_START;
               end
            end
            S_START: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (core_done) begin
                  r_acc   <= core_ghash;
                  r_state <= r_last_q ? S_OUT : S_LOAD;
               end
            end
            S_OUT: begin
               if (m_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Constant 0: no watchdog exists in this build (limit must be positive).
   assign err = (WDOG_CYCLES < 0);
`endif

   // Handshake strobes are plain state decodes, forced low during reset.
   assign cfg_ready   = !reset && (r_state == S_IDLE);
   assign s_ready     = !reset && (r_state == S_LOAD);
   assign m_valid     = !reset && (r_state == S_OUT);
   assign busy        = (r_state != S_IDLE);

   // The accumulator doubles as the chaining input and the final result.
   assign m_ghash     = r_acc;
   assign core_g_prev = r_acc;
   assign core_data   = r_data;
   assign core_subkey = r_subkey;
   assign core_en     = r_core_en;

endmodule

// File: tb/tb_ghash_sequencer.sv
// Directed bench for ghash_sequencer with a behavioural stand-in for the
// ghash core (fixed latency D, table entry for the reference vector).
module tb_ghash_sequencer;

   localparam int D = 3;

   localparam logic [127:0] H_A = 128'hfe62256362600ac766636f962bb05f66;
   localparam logic [127:0] H_B = 128'h0123456789abcdef0011223344556677;
   localparam logic [127:0] X1  = 128'h7d924cfd37b3d046a96eb5e132042405;
   localparam logic [127:0] G1  = 128'h0c33e33e3288ca631ca47544293d03ee;
   localparam logic [127:0] X2  = 128'h00112233445566778899aabbccddeeff;

   logic         clk = 1'b0;
   logic         reset;
   logic         cfg_valid;
   logic         cfg_ready;
   logic [127:0] cfg_subkey;
   logic         s_valid;
   logic         s_ready;
   logic [127:0] s_data;
   logic         s_last;
   logic         m_valid;
   logic         m_ready;
   logic [127:0] m_ghash;
   logic         core_en;
   logic [127:0] core_g_prev;
   logic [127:0] core_data;
   logic [127:0] core_subkey;
   logic [127:0] core_ghash;
   logic         core_done;
   logic         busy;
   logic         err;

   // core stand-in state
   logic         stub_on = 1'b1;
   logic         stub_done = 1'b0;
   logic [127:0] stub_res = '0;
   int           stub_cnt = 0;
   logic         man_done = 1'b0;
   logic [127:0] man_res = '0;
   int           en_cnt = 0;

   int n_chk = 0;
   int n_fail = 0;

   assign core_done  = stub_on ? stub_done : man_done;
   assign core_ghash = stub_on ? stub_res : man_res;

   ghash_sequencer #(
      .GHASH_BITS (128),
      .SUBKEY_BITS(128),
      .WDOG_CYCLES(16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_subkey (cfg_subkey),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_ghash    (m_ghash),
      .core_en    (core_en),
      .core_g_prev(core_g_prev),
      .core_data  (core_data),
      .core_subkey(core_subkey),
      .core_ghash (core_ghash),
      .core_done  (core_done),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Stand-in core result: reference vector by table, otherwise a simple
   // asymmetric mix so that swapped or stale operands change the answer.
   function automatic logic [127:0] core_fn(input logic [127:0] g, input logic [127:0] d,
                                            input logic [127:0] h);
      if (g == '0 && d == X1 && h == H_A) return G1;
      return {g[119:0], g[127:120]} ^ d ^ ~h;
   endfunction

   // Core stand-in: done pulses D cycles after the en cycle.
   always @(negedge clk) begin
      stub_done = 1'b0;
      if (!stub_on) begin
         stub_cnt = 0;
      end else begin
         if (stub_cnt > 0) begin
            stub_cnt = stub_cnt - 1;
            if (stub_cnt == 0) stub_done = 1'b1;
         end
         if (core_en) begin
            stub_cnt = D;
            stub_res = core_fn(core_g_prev, core_data, core_subkey);
         end
      end
   end

   always @(negedge clk) begin
      if (core_en === 1'b1) en_cnt = en_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, observed hang, required finish");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_i(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs == exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_mvalid(input int max, output int n);
      n = 0;
      while (m_valid !== 1'b1 && n < max) begin
         step();
         n++;
      end
   endtask

   task automatic wait_en(input int max, output int n);
      n = 0;
      while (core_en !== 1'b1 && n < max) begin
         step();
         n++;
      end
   endtask

   initial begin
      int n;
      int en0;
      reset      = 1'b1;
      cfg_valid  = 1'b0;
      cfg_subkey = '0;
      s_valid    = 1'b0;
      s_data     = '0;
      s_last     = 1'b0;
      m_ready    = 1'b0;

      // Reset state
      step(); step(); step();
      chk1("rst_cfg_ready", cfg_ready, 1'b0);
      chk1("rst_s_ready", s_ready, 1'b0);
      chk1("rst_m_valid", m_valid, 1'b0);
      chk1("rst_core_en", core_en, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_err", err, 1'b0);
      chk("rst_m_ghash", m_ghash, '0);
      chk("rst_g_prev", core_g_prev, '0);
      chk("rst_core_data", core_data, '0);
      chk("rst_core_subkey", core_subkey, '0);
      reset = 1'b0;
      step();
      chk1("idle_cfg_ready", cfg_ready, 1'b1);

      // Single block with s_last
      cfg_valid = 1'b1; cfg_subkey = H_A;
      s_valid = 1'b1; s_data = X1; s_last = 1'b1;
      step();
      cfg_valid = 1'b0;
      chk("t1_subkey", core_subkey, H_A);
      chk1("t1_s_ready", s_ready, 1'b1);
      chk1("t1_cfg_ready", cfg_ready, 1'b0);
      chk1("t1_busy", busy, 1'b1);
      step();
      s_valid = 1'b0;
      chk1("t1_core_en", core_en, 1'b1);
      chk("t1_g_prev", core_g_prev, '0);
      chk("t1_core_data", core_data, X1);
      wait_mvalid(20, n);
      chk_i("t1_latency", n, D + 1);
      chk("t1_m_ghash", m_ghash, G1);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      chk1("t1_m_valid_drop", m_valid, 1'b0);
      chk1("t1_cfg_ready_back", cfg_ready, 1'b1);

      // Two blocks, cfg pulses in LOAD and WAIT, s_valid held through WAIT
      cfg_valid = 1'b1; cfg_subkey = H_A;
      step();
      en0 = en_cnt;
      cfg_subkey = H_B;
      s_valid = 1'b1; s_data = X1; s_last = 1'b0;
      step();
      cfg_valid = 1'b0;
      s_data = X2; s_last = 1'b1;
      chk("t2_subkey_load", core_subkey, H_A);
      chk1("t2_core_en1", core_en, 1'b1);
      chk("t2_g_prev1", core_g_prev, '0);
      chk("t2_core_data1", core_data, X1);
      step();
      cfg_valid = 1'b1; cfg_subkey = H_B;
      step();
      cfg_valid = 1'b0;
      chk("t2_subkey_wait", core_subkey, H_A);
      chk("t2_data_hold", core_data, X1);
      chk1("t2_s_ready_wait", s_ready, 1'b0);
      chk1("t2_busy", busy, 1'b1);
      wait_en(20, n);
      chk_i("t2_spacing", n + 2, D + 2);
      chk("t2_g_prev2", core_g_prev, G1);
      chk("t2_core_data2", core_data, X2);
      chk("t2_subkey2", core_subkey, H_A);
      s_valid = 1'b0;
      wait_mvalid(20, n);
      chk_i("t2_out_latency", n, D + 1);
      chk("t2_m_ghash", m_ghash, core_fn(G1, X2, H_A));
      // Backpressure
      for (int i = 0; i < 10; i++) begin
         step();
         chk1("bp_m_valid", m_valid, 1'b1);
         chk("bp_m_ghash", m_ghash, core_fn(G1, X2, H_A));
         chk1("bp_cfg_ready", cfg_ready, 1'b0);
         chk1("bp_s_ready", s_ready, 1'b0);
      end
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      chk_i("t2_en_count", en_cnt - en0, 2);
      chk1("t2_m_valid_drop", m_valid, 1'b0);

      // Reset mid-WAIT, late core_done ignored
      stub_on = 1'b0;
      cfg_valid = 1'b1; cfg_subkey = H_B;
      s_valid = 1'b1; s_data = X1; s_last = 1'b1;
      step();
      cfg_valid = 1'b0;
      step();
      s_valid = 1'b0;
      step();
      chk1("t3_busy_wait", busy, 1'b1);
      reset = 1'b1;
      step();
      chk1("t3_rst_cfg_ready", cfg_ready, 1'b0);
      chk1("t3_rst_m_valid", m_valid, 1'b0);
      chk1("t3_rst_busy", busy, 1'b0);
      chk1("t3_rst_core_en", core_en, 1'b0);
      chk("t3_rst_g_prev", core_g_prev, '0);
      chk("t3_rst_subkey", core_subkey, '0);
      chk("t3_rst_data", core_data, '0);
      reset = 1'b0;
      man_done = 1'b1; man_res = '1;
      step();
      man_done = 1'b0;
      step();
      chk("t3_acc_after_done", core_g_prev, '0);
      chk1("t3_busy_after", busy, 1'b0);
      chk1("t3_cfg_ready_after", cfg_ready, 1'b1);
      chk1("t3_m_valid_after", m_valid, 1'b0);
      stub_on = 1'b1;
      cfg_valid = 1'b1; cfg_subkey = H_B;
      s_valid = 1'b1; s_data = X2; s_last = 1'b1;
      step();
      cfg_valid = 1'b0;
      step();
      s_valid = 1'b0;
      chk("t3_next_subkey", core_subkey, H_B);
      chk("t3_next_g_prev", core_g_prev, '0);
      wait_mvalid(20, n);
      chk_i("t3_next_latency", n, D + 1);
      chk("t3_next_m_ghash", m_ghash, core_fn('0, X2, H_B));
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;

      // Core never answers
      stub_on = 1'b0;
      cfg_valid = 1'b1; cfg_subkey = H_A;
      s_valid = 1'b1; s_data = X1; s_last = 1'b1;
      step();
      cfg_valid = 1'b0;
      step();
      s_valid = 1'b0;
      chk1("t4_core_en", core_en, 1'b1);
`ifdef GHASH_SEQ_WDOG_EN
      for (int i = 0; i < 16; i++) begin
         step();
         chk1("wd_err_low", err, 1'b0);
         chk1("wd_busy", busy, 1'b1);
      end
      step();
      chk1("wd_err_set", err, 1'b1);
      chk1("wd_cfg_ready", cfg_ready, 1'b1);
      chk1("wd_busy_idle", busy, 1'b0);
      chk1("wd_no_m_valid", m_valid, 1'b0);
      cfg_valid = 1'b1; cfg_subkey = H_B;
      step();
      cfg_valid = 1'b0;
      chk1("wd_err_cleared", err, 1'b0);
      chk("wd_new_subkey", core_subkey, H_B);
`else
      for (int i = 0; i < 20; i++) begin
         step();
         chk1("nowd_err", err, 1'b0);
         chk1("nowd_busy", busy, 1'b1);
      end
      chk1("nowd_no_m_valid", m_valid, 1'b0);
`endif
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      chk1("final_idle", cfg_ready, 1'b1);
      chk1("final_err", err, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ghash_sequencer.md
# ghash_sequencer

Controller that runs a multi-block GHASH computation over the existing `ghash` core. It accepts a hash subkey H, then a stream of 128-bit data blocks. For each block it feeds the core with the previous partial hash as `g_prev`, pulses `en` and waits for `done`. After the block flagged `last`, it presents the final hash on a valid/ready output. The block sits between the GCM mode control/AXI stream logic and the `ghash` core instance.

## Interface
Parameters:
- `GHASH_BITS`, 128, width of data blocks and of the hash.
- `SUBKEY_BITS`, 128, width of H.
- `WDOG_CYCLES`, 64, watchdog limit in cycles. Used only with `GHASH_SEQ_WDOG_EN`.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `cfg_valid`  in  1  new hash request.
- `cfg_ready`  out  1  request can be accepted.
- `cfg_subkey`  in  SUBKEY_BITS  H for this hash.
- `s_valid`  in  1  data block valid.
- `s_ready`  out  1  block accepted when high together with `s_valid`.
- `s_data`  in  GHASH_BITS  data block.
- `s_last`  in  1  marks the final block of the message.
- `m_valid`  out  1  final hash valid.
- `m_ready`  in  1  consumer accepts the hash.
- `m_ghash`  out  GHASH_BITS  final hash.
- `core_en`  out  1  one-cycle start pulse to the core.
- `core_g_prev`  out  GHASH_BITS  accumulator value driven to the core.
- `core_data`  out  GHASH_BITS  latched block driven to the core.
- `core_subkey`  out  SUBKEY_BITS  latched H driven to the core.
- `core_ghash`  in  GHASH_BITS  core result.
- `core_done`  in  1  core completion; a one-cycle pulse, at least 1 cycle after `core_en`.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  watchdog error flag.

## Operation
State machine: IDLE, LOAD, START, WAIT, OUT.
- **IDLE:** `cfg_ready`=1. On `cfg_valid`:
  - latch H into `core_subkey`;
  - clear the accumulator to 0;
  - clear `err`;
  - go to LOAD.
- **LOAD:** `s_ready`=1. On `s_valid`:
  - latch `s_data` into `core_data`;
  - latch `s_last` into `last_q`;
  - go to START.
- **START:** `core_en`=1 for exactly this cycle. Go to WAIT.
- **WAIT:** on `core_done`:
  - accumulator ← `core_ghash`;
  - if `last_q`, go to OUT; otherwise go to LOAD.
- **OUT:** `m_valid`=1 and `m_ghash`=accumulator. On `m_ready`, go to IDLE.

Held values and sampling rules:
- `core_g_prev` always equals the accumulator.
- `core_data`, `core_subkey` and `core_g_prev` stay constant from START until `core_done` is sampled.
- `core_done` is sampled only in WAIT; in any other state it is ignored.
- `cfg_ready`, `s_ready` and `m_valid` are combinational decodes of the state. All are 0 while `reset` is high.
- `m_ghash` holds stable while `m_valid && !m_ready`.

Boundary conditions:
- `s_last` on the first block produces a single-block hash.
- Zero-block messages are not supported.
- `cfg_valid` outside IDLE is ignored and has no effect on H.
- `s_valid` outside LOAD is ignored; the upstream source must hold the block.
- Reset in any state returns to IDLE:
  - accumulator, `core_data`, `core_subkey` and `last_q` are cleared to 0;
  - `core_en`=0 and `err`=0;
  - a `core_done` arriving after reset is ignored.

## Timing
- Reset values: `cfg_ready`, `s_ready`, `m_valid`, `core_en`, `busy` and `err` are 0. `m_ghash`, `core_g_prev`, `core_data` and `core_subkey` are 0. State is IDLE. `cfg_ready` rises in the first cycle after `reset` falls.
- Let D be the number of cycles from `core_en` to `core_done`. Per block, the sequence is:
  1. LOAD accept (1 cycle);
  2. START (1 cycle);
  3. WAIT (D cycles).
- Block-to-block spacing is therefore D+2 cycles when `s_valid` is held high.
- `m_valid` rises the cycle after the final `core_done`.
- End-to-end latency for N blocks, measured from the `cfg_valid` accept cycle, is 1 + N·(D+2) cycles to `m_valid`.

## Configuration
- **`GHASH_SEQ_WDOG_EN` defined:**
  - a counter clears on entry to WAIT and increments each WAIT cycle;
  - if it reaches `WDOG_CYCLES` without `core_done`, `err` is set and the FSM goes to IDLE;
  - no `m_valid` is produced in that case;
  - `err` stays high until the next `cfg_valid` accept or reset.
- **Not defined:** the counter is absent, `err` is tied to 0, and WAIT lasts indefinitely.

## Test plan
- **Single block:** H=fe62256362600ac766636f962bb05f66, block 7d924cfd37b3d046a96eb5e132042405 with `s_last`=1 -> `core_g_prev`=0 at `core_en`. Then `m_valid` with `m_ghash`=0c33e33e3288ca631ca47544293d03ee.
- **Two blocks:** same H, first block above with `s_last`=0, then a second block with `s_last`=1 -> second `core_en` sees `core_g_prev`=0c33e33e3288ca631ca47544293d03ee. `m_ghash` matches the software GHASH model.
- **Backpressure:** `m_ready` held 0 for 10 cycles in OUT -> `m_valid` and `m_ghash` stable. `cfg_ready`=0 and `s_ready`=0 throughout.
- **Protocol checks:**
  - `cfg_valid` pulsed in LOAD and WAIT -> ignored, H unchanged;
  - `s_valid` held high during WAIT -> no second capture;
  - exactly one `core_en` per block.
- **Reset mid-WAIT:** assert `reset` in WAIT, then deliver `core_done` the next cycle -> IDLE, accumulator 0, no `m_valid`. A following hash is correct.
- **Watchdog (macro on, `WDOG_CYCLES`=16):** core never asserts `core_done` -> `err`=1 after 16 WAIT cycles, state IDLE, `cfg_ready`=1. The next `cfg_valid` accept clears `err`.
